// File: rtl/vga_timing_gen.sv
// Raster timing source: hc/vc counters, coordinate decode and a delayed sync/DE/RGB monitor path.
// Optional colour-bar override is compiled in with `define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 1280,
   parameter int unsigned H_FP       = 48,
   parameter int unsigned H_SYNC     = 112,
   parameter int unsigned H_BP       = 248,
   parameter int unsigned V_ACTIVE   = 1024,
   parameter int unsigned V_FP       = 1,
   parameter int unsigned V_SYNC     = 3,
   parameter int unsigned V_BP       = 38,
   parameter bit          SYNC_POL   = 1'b1,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [10:0] o_x,
   output logic [9:0]  o_y,
   output logic        o_valid,
   output logic        o_vsync,
   output logic        o_frame_start,
   output logic [15:0] o_frame_count,
   input  logic [7:0]  i_r_in,
   input  logic [7:0]  i_g_in,
   input  logic [7:0]  i_b_in,
   input  logic        i_pattern_en,
   output logic        o_hsync_out,
   output logic        o_vsync_out,
   output logic        o_de_out,
   output logic [7:0]  o_r_out,
   output logic [7:0]  o_g_out,
   output logic [7:0]  o_b_out
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] r_hc;
   logic [VW-1:0] r_vc;
   logic [15:0]   r_fc;
   logic          w_h_end;
   logic          w_v_end;
   logic          w_hs_act;
   logic          w_vs_act;

   // Delay-line stage bits: {hsync active, vsync active, data enable}
   logic [2:0]    r_dly [PIPE_DELAY];
   logic [7:0]    r_r;
   logic [7:0]    r_g;
   logic [7:0]    r_b;
   logic [7:0]    w_r_src;
   logic [7:0]    w_g_src;
   logic [7:0]    w_b_src;

   assign w_h_end  = (r_hc == H_LAST);
   assign w_v_end  = (r_vc == V_LAST);
   assign w_hs_act = (r_hc >= HS_BEG) && (r_hc < HS_END);
   assign w_vs_act = (r_vc >= VS_BEG) && (r_vc < VS_END);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hc <= '0;
         r_vc <= '0;
         r_fc <= '0;
      end else if (w_h_end) begin
         r_hc <= '0;
         if (w_v_end) begin
            r_vc <= '0;
            r_fc <= r_fc + 16'd1;
         end else begin
            r_vc <= r_vc + VW'(1);
         end
      end else begin
         r_hc <= r_hc + HW'(1);
      end
   end

   always_comb begin
      o_valid       = (r_hc < H_ACT) && (r_vc < V_ACT);
      o_x           = o_valid ? 11'(r_hc) : 11'd0;
      o_y           = o_valid ? 10'(r_vc) : 10'd0;
      o_vsync       = ~w_vs_act;
      o_frame_start = (r_hc == '0) && (r_vc == '0);
      o_frame_count = r_fc;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < PIPE_DELAY; i++) r_dly[i] <= '0;
         r_r <= '0;
         r_g <= '0;
         r_b <= '0;
      end else begin
         r_dly[0] <= {w_hs_act, w_vs_act, o_valid};
         for (int i = 1; i < PIPE_DELAY; i++) r_dly[i] <= r_dly[i-1];
         r_r <= i_r_in;
         r_g <= i_g_in;
         r_b <= i_b_in;
      end
   end

`ifdef VGA_TIMING_TEST_PATTERN_EN
   // Bar index x[10:8] travels with the sync bits so bars line up with de_out
   logic [2:0] r_bar [PIPE_DELAY];
   logic [2:0] w_bar;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < PIPE_DELAY; i++) r_bar[i] <= '0;
      end else begin
         r_bar[0] <= o_x[10:8];
         for (int i = 1; i < PIPE_DELAY; i++) r_bar[i] <= r_bar[i-1];
      end
   end

   assign w_bar = r_bar[PIPE_DELAY-1];

   always_comb begin
      w_r_src = r_r;
      w_g_src = r_g;
      w_b_src = r_b;
      if (i_pattern_en) begin
         w_r_src = {8{~w_bar[1]}};
         w_g_src = {8{~w_bar[2]}};
         w_b_src = {8{~w_bar[0]}};
      end
   end
`else
   logic w_unused_pattern_en;
   assign w_unused_pattern_en = i_pattern_en;

   always_comb begin
      w_r_src = r_r;
      w_g_src = r_g;
      w_b_src = r_b;
   end
`endif

   always_comb begin
      o_hsync_out = r_dly[PIPE_DELAY-1][2] ? SYNC_POL : ~SYNC_POL;
      o_vsync_out = r_dly[PIPE_DELAY-1][1] ? SYNC_POL : ~SYNC_POL;
      o_de_out    = r_dly[PIPE_DELAY-1][0];
      o_r_out     = o_de_out ? w_r_src : 8'd0;
      o_g_out     = o_de_out ? w_g_src : 8'd0;
      o_b_out     = o_de_out ? w_b_src : 8'd0;
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (25 x 13 clocks per frame).
// Driver pushes per-cycle expectations from a cycle-index model; a negedge monitor compares.
module tb_vga_timing_gen;

   localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
   localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
   localparam int HT = HA + HFP + HSW + HBP;   // 25
   localparam int VT = VA + VFP + VSW + VBP;   // 13
   localparam int PD = 2;
   localparam bit POL = 1'b1;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        valid;
      logic        vsync;
      logic        fs;
      logic [15:0] fc;
      logic        hs_o;
      logic        vs_o;
      logic        de_o;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] x;
   logic [9:0]  y;
   logic        valid, vsync, frame_start;
   logic [15:0] frame_count;
   logic [7:0]  r_in, g_in, b_in;
   logic        pattern_en;
   logic        hsync_out, vsync_out, de_out;
   logic [7:0]  r_out, g_out, b_out;

   exp_t exp_q [$];
   int   t_q [$];
   bit   tag_q [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cnt_valid = 0, cnt_fs = 0, cnt_hs = 0, cnt_delow = 0, cnt_vsl = 0, cnt_vso = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(POL), .PIPE_DELAY(PD)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .o_x(x), .o_y(y), .o_valid(valid), .o_vsync(vsync),
      .o_frame_start(frame_start), .o_frame_count(frame_count),
      .i_r_in(r_in), .i_g_in(g_in), .i_b_in(b_in), .i_pattern_en(pattern_en),
      .o_hsync_out(hsync_out), .o_vsync_out(vsync_out), .o_de_out(de_out),
      .o_r_out(r_out), .o_g_out(g_out), .o_b_out(b_out)
   );

   // Expected outputs t clocks after reset release, derived from the cycle index alone
   function automatic exp_t model(int t);
      exp_t        e;
      int          hc, vc, td, hd, vd;
      logic [10:0] xd;
      hc = t % HT;
      vc = (t / HT) % VT;
      e = '0;
      e.valid = (hc < HA) && (vc < VA);
      e.x     = e.valid ? 11'(hc) : 11'd0;
      e.y     = e.valid ? 10'(vc) : 10'd0;
      e.vsync = !((vc >= VA + VFP) && (vc < VA + VFP + VSW));
      e.fs    = (hc == 0) && (vc == 0);
      e.fc    = 16'(t / (HT * VT));
      e.hs_o  = !POL;
      e.vs_o  = !POL;
      e.de_o  = 1'b0;
      if (t >= PD) begin
         td = t - PD;
         hd = td % HT;
         vd = (td / HT) % VT;
         e.hs_o = ((hd >= HA + HFP) && (hd < HA + HFP + HSW)) ? POL : !POL;
         e.vs_o = ((vd >= VA + VFP) && (vd < VA + VFP + VSW)) ? POL : !POL;
         e.de_o = (hd < HA) && (vd < VA);
         if (e.de_o) begin
            xd  = 11'(hd);
            e.r = xd[7:0];
            e.g = xd[7:0] ^ 8'h55;
            e.b = xd[7:0] ^ 8'h0F;
         end
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   // Drive cycle t: stimulus, then push expectation; display answers pixel t-1 with its x
   task automatic step(input int t, input bit tag, input logic rst);
      exp_t prev;
      reset = rst;
      r_in = 8'hAA; g_in = 8'hAA; b_in = 8'hAA;
      if (t >= 1) begin
         prev = model(t - 1);
         if (prev.valid) begin
            r_in = prev.x[7:0];
            g_in = prev.x[7:0] ^ 8'h55;
            b_in = prev.x[7:0] ^ 8'h0F;
         end
      end
      exp_q.push_back(model(t));
      t_q.push_back(t);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e, a;
      int   t;
      bit   tag;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = t_q.pop_front();
            tag = tag_q.pop_front();
            a   = '{x, y, valid, vsync, frame_start, frame_count, hsync_out, vsync_out, de_out,
                    r_out, g_out, b_out};
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL raster t=%0d: got x=%0d y=%0d v=%b vs=%b fs=%b fc=%0d hso=%b vso=%b de=%b rgb=%h_%h_%h, required x=%0d y=%0d v=%b vs=%b fs=%b fc=%0d hso=%b vso=%b de=%b rgb=%h_%h_%h",
                        t, a.x, a.y, a.valid, a.vsync, a.fs, a.fc, a.hs_o, a.vs_o, a.de_o,
                        a.r, a.g, a.b, e.x, e.y, e.valid, e.vsync, e.fs, e.fc, e.hs_o, e.vs_o,
                        e.de_o, e.r, e.g, e.b);
            end
            if (tag) begin
               cnt_valid += int'(valid);
               cnt_fs    += int'(frame_start);
               cnt_hs    += int'(hsync_out == POL);
               cnt_delow += int'(!de_out);
               cnt_vsl   += int'(!vsync);
               cnt_vso   += int'(vsync_out == POL);
            end
         end
      end
   end

   initial begin : driver
      reset = 1'b1;
      pattern_en = 1'b0;
      r_in = 8'hAA; g_in = 8'hAA; b_in = 8'hAA;
      repeat (3) @(posedge clk);
      #1;
      // Two complete frames from reset; aggregate counts below are tallied over these 650 cycles
      for (int t = 0; t < 2 * HT * VT; t++) step(t, 1'b1, 1'b0);
      // Continue into frame 3 up to hc=5, vc=3, then reset for one clock
      for (int t = 2 * HT * VT; t < 2 * HT * VT + 3 * HT + 5; t++) step(t, 1'b0, 1'b0);
      step(2 * HT * VT + 3 * HT + 5, 1'b0, 1'b1);
      for (int t = 0; t < 400; t++) step(t, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("valid_cycles_2frames", cnt_valid, 256);
      chk("frame_start_pulses", cnt_fs, 2);
      chk("hsync_out_active_cycles", cnt_hs, 78);
      chk("de_out_low_cycles", cnt_delow, 394);
      chk("vsync_low_cycles", cnt_vsl, 100);
      chk("vsync_out_active_cycles", cnt_vso, 100);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
